// File: rtl/hub75_scan_gen_pkg.sv
// Shared definitions for the HUB75 scan generator: FSM encoding, RGB565 layout,
// frame-buffer address fields, pixels_per_row special values and bit-plane selection.
package hub75_scan_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4,
    ST_NEXT    = 3'd5
  } state_e;

  localparam int unsigned R_LSB = 11;
  localparam int unsigned R_W   = 5;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned G_W   = 6;
  localparam int unsigned B_LSB = 0;
  localparam int unsigned B_W   = 5;

  localparam int unsigned ROW_W = 6;
  localparam int unsigned COL_W = 9;

  localparam int unsigned PPR_ZERO_COLS = 64;
  localparam int unsigned PPR_MAX_COLS  = 512;

  function automatic logic [9:0] eff_cols(input logic [9:0] ppr);
    if (ppr == 10'd0) return 10'(PPR_ZERO_COLS);
    if (ppr > 10'(PPR_MAX_COLS)) return 10'(PPR_MAX_COLS);
    return ppr;
  endfunction

  // Plane p uses the top nplanes bits of each colour field, LSB-first.
  function automatic logic [2:0] plane_bits(input logic [15:0] pix, input logic [1:0] plane,
                                            input int unsigned nplanes);
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
    logic [2:0]     rb_idx;
    logic [2:0]     g_idx;
    r      = pix[R_LSB +: R_W];
    g      = pix[G_LSB +: G_W];
    b      = pix[B_LSB +: B_W];
    rb_idx = {1'b0, plane} + 3'(R_W - nplanes);
    g_idx  = {1'b0, plane} + 3'(G_W - nplanes);
    return {r[rb_idx], g[g_idx], b[rb_idx]};
  endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// Display-time down-counter: load_i loads BASE_OE<<plane_i, run_i decrements it.
// done_o is high in the last counted cycle, so a run lasts exactly the loaded count.
module hub75_oe_timer
#(
  parameter int unsigned BASE_OE = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       load_i,
  input  logic       run_i,
  input  logic [1:0] plane_i,
  output logic       done_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 16'(BASE_OE) << plane_i;
    end else if (run_i && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q <= 16'd1);

endmodule

// File: rtl/hub75_scan_gen.sv
// HUB75 scan generator: per row and bit-plane, reads upper/lower pixels (4 cycles per column),
// shifts them out, blanks, latches and holds OE low for BASE_OE<<plane cycles; enable low aborts to IDLE.
module hub75_scan_gen
  import hub75_scan_gen_pkg::*;
#(
  parameter int unsigned BASE_OE    = 16,
  parameter int unsigned NUM_PLANES = 4
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        enable,
  input  logic [9:0]  pixels_per_row,
  output logic        mem_rd,
  output logic [14:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  output logic        hub_r1,
  output logic        hub_g1,
  output logic        hub_b1,
  output logic        hub_r2,
  output logic        hub_g2,
  output logic        hub_b2,
  output logic [3:0]  hub_addr,
  output logic        hub_clk,
  output logic        hub_lat,
  output logic        hub_oe_n,
  output logic        frame_done
);

  state_e           state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [1:0]       plane_q, plane_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       ph_q, ph_d;
  logic [9:0]       ncols_q, ncols_d;
  logic [3:0]       hub_addr_q, hub_addr_d;
  logic [15:0]      upper_q;
  logic [5:0]       rgb_q, rgb_new, rgb_out;
  logic [ROW_W-1:0] raddr_row;
  logic             last_col, last_plane, oe_done, timer_load, disp_run;

  // 10-bit compare so that N=512 terminates at col 511 without wrapping.
  assign last_col   = ({1'b0, col_q} == (ncols_q - 10'd1));
  assign last_plane = (plane_q == 2'(NUM_PLANES - 1));
  assign rgb_new    = {plane_bits(upper_q, plane_q, NUM_PLANES),
                       plane_bits(mem_rdata, plane_q, NUM_PLANES)};

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_SHIFT;
        ST_SHIFT:   if ((ph_q == 2'd3) && last_col) state_d = ST_BLANK;
        ST_BLANK:   state_d = ST_LATCH;
        ST_LATCH:   state_d = ST_DISPLAY;
        ST_DISPLAY: if (oe_done) state_d = ST_NEXT;
        ST_NEXT:    state_d = ST_SHIFT;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd     = 1'b0;
    raddr_row  = '0;
    mem_raddr  = '0;
    hub_clk    = 1'b0;
    hub_lat    = 1'b0;
    hub_oe_n   = 1'b1;
    frame_done = 1'b0;
    timer_load = 1'b0;
    disp_run   = 1'b0;
    rgb_out    = rgb_q;
    case (state_q)
      ST_SHIFT: begin
        case (ph_q)
          2'd0: begin
            mem_rd    = 1'b1;
            raddr_row = {2'b00, row_q};
            mem_raddr = {raddr_row, col_q};
          end
          2'd1: begin
            mem_rd    = 1'b1;
            raddr_row = {2'b01, row_q};
            mem_raddr = {raddr_row, col_q};
          end
          2'd2:    rgb_out = rgb_new;
          default: hub_clk = 1'b1;
        endcase
      end
      ST_LATCH: begin
        hub_lat    = 1'b1;
        timer_load = 1'b1;
      end
      ST_DISPLAY: begin
        hub_oe_n = 1'b0;
        disp_run = 1'b1;
      end
      ST_NEXT:  frame_done = last_plane && (row_q == 4'd15);
      default: ;
    endcase
  end

  assign {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = rgb_out;
  assign hub_addr = hub_addr_q;

  always_comb begin
    row_d      = row_q;
    plane_d    = plane_q;
    col_d      = col_q;
    ph_d       = ph_q;
    ncols_d    = ncols_q;
    hub_addr_d = hub_addr_q;
    if (!enable) begin
      row_d   = '0;
      plane_d = '0;
      col_d   = '0;
      ph_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ncols_d = eff_cols(pixels_per_row);
          row_d   = '0;
          plane_d = '0;
          col_d   = '0;
          ph_d    = '0;
        end
        ST_SHIFT: begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd3) col_d = last_col ? '0 : col_q + 9'd1;
        end
        ST_BLANK: hub_addr_d = row_q;
        ST_NEXT: begin
          // Column count is only re-sampled here so a row never changes width mid-shift.
          ncols_d = eff_cols(pixels_per_row);
          col_d   = '0;
          ph_d    = '0;
          if (last_plane) begin
            plane_d = '0;
            row_d   = row_q + 4'd1;
          end else begin
            plane_d = plane_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      row_q      <= '0;
      plane_q    <= '0;
      col_q      <= '0;
      ph_q       <= '0;
      ncols_q    <= '0;
      hub_addr_q <= '0;
      upper_q    <= '0;
      rgb_q      <= '0;
    end else begin
      row_q      <= row_d;
      plane_q    <= plane_d;
      col_q      <= col_d;
      ph_q       <= ph_d;
      ncols_q    <= ncols_d;
      hub_addr_q <= hub_addr_d;
      if ((state_q == ST_SHIFT) && (ph_q == 2'd1)) upper_q <= mem_rdata;
      if ((state_q == ST_SHIFT) && (ph_q == 2'd2)) rgb_q <= rgb_new;
    end
  end

  hub75_oe_timer #(.BASE_OE(BASE_OE)) u_oe_timer (
    .pclk    (pclk),
    .presetn (presetn),
    .load_i  (timer_load),
    .run_i   (disp_run),
    .plane_i (plane_q),
    .done_o  (oe_done)
  );

endmodule

// File: tb/tb_hub75_scan_gen.sv
// Scoreboard bench for hub75_scan_gen: directed scans push expected reads, shifted pixels,
// latch rows and OE widths into queues; negedge monitors pop and compare against the DUT.
`timescale 1ns/1ps
module tb_hub75_scan_gen;

  localparam int BASE_OE = 16;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  ppr = 10'd64;
  logic        mem_rd;
  logic [14:0] mem_raddr;
  logic [15:0] mem_rdata = 16'h0;
  logic        hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
  logic [3:0]  hub_addr;
  logic        hub_clk, hub_lat, hub_oe_n, frame_done;

  always #5 pclk = ~pclk;

  hub75_scan_gen #(.BASE_OE(BASE_OE), .NUM_PLANES(4)) dut (
    .pclk(pclk), .presetn(presetn), .enable(enable), .pixels_per_row(ppr),
    .mem_rd(mem_rd), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
    .hub_addr(hub_addr), .hub_clk(hub_clk), .hub_lat(hub_lat),
    .hub_oe_n(hub_oe_n), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;
  int mem_mode = 0;
  int cyc = 0;
  int rd_cnt = 0, disp_cnt = 0, lat_cnt = 0, fd_cnt = 0, clk_cnt = 0;
  bit chk_rd = 1, chk_pix = 1, chk_oe = 1;

  logic [14:0] exp_rd_q[$];
  logic [5:0]  exp_pix_q[$];
  logic [3:0]  exp_lat_q[$];
  int          exp_oe_q[$];
  int          start_q[$];
  int          lat_cyc_q[$];
  int          fd_q[$];

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    if (mem_mode == 0) return {1'b0, a};
    return a[13] ? 16'h0000 : 16'h8410;
  endfunction

  // NUM_PLANES=4: R5[p+1] is pix[12+p], G6[p+2] is pix[7+p], B5[p+1] is pix[1+p].
  function automatic logic [2:0] pb(input logic [15:0] pix, input int p);
    return {pix[12+p], pix[7+p], pix[1+p]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem_word(mem_raddr);
  end

  logic clk_prev = 1'b0, oe_prev = 1'b1;
  int   oe_len = 0;
  always @(negedge pclk) begin
    if (presetn) begin
      if (mem_rd) begin
        rd_cnt++;
        if (mem_raddr == 15'd0) start_q.push_back(cyc);
        if (chk_rd) begin
          if (exp_rd_q.size() == 0) fail_evt("read addr", mem_raddr);
          else check("read addr", mem_raddr, exp_rd_q.pop_front());
        end
      end
      if (hub_clk && !clk_prev) begin
        clk_cnt++;
        if (chk_pix) begin
          if (exp_pix_q.size() == 0) fail_evt("shift rgb", {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2});
          else check("shift rgb", {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}, exp_pix_q.pop_front());
        end
      end
      if (hub_lat) begin
        lat_cnt++;
        lat_cyc_q.push_back(cyc);
        if (exp_lat_q.size() == 0) fail_evt("latch row", hub_addr);
        else check("latch row", hub_addr, exp_lat_q.pop_front());
      end
      if (!hub_oe_n) begin
        oe_len++;
      end else if (!oe_prev) begin
        disp_cnt++;
        if (chk_oe) begin
          if (exp_oe_q.size() == 0) fail_evt("oe width", oe_len);
          else check("oe width", oe_len, exp_oe_q.pop_front());
        end
        oe_len = 0;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_q.push_back(cyc);
      end
      clk_prev = hub_clk;
      oe_prev  = hub_oe_n;
    end
  end

  task automatic push_cols(input int row, input int plane, input int nrd, input int npix);
    for (int c = 0; c < nrd; c++) begin
      logic [14:0] a0, a1;
      a0 = {2'b00, 4'(row), 9'(c)};
      a1 = {2'b01, 4'(row), 9'(c)};
      exp_rd_q.push_back(a0);
      exp_rd_q.push_back(a1);
      if (c < npix) exp_pix_q.push_back({pb(mem_word(a0), plane), pb(mem_word(a1), plane)});
    end
  endtask

  task automatic push_tail(input int row, input int plane);
    exp_lat_q.push_back(4'(row));
    exp_oe_q.push_back(BASE_OE << plane);
  endtask

  function automatic int cnt_of(input int kind);
    case (kind)
      0:       return disp_cnt;
      1:       return rd_cnt;
      default: return fd_cnt;
    endcase
  endfunction

  // Returns just after a negedge, so a following enable=0 stops the FSM at the next edge.
  task automatic wait_cnt(input int kind, input int target, input int budget, input string name);
    int n = 0;
    while (cnt_of(kind) < target && n < budget) begin
      @(negedge pclk);
      #1;
      n++;
    end
    if (cnt_of(kind) < target) fail_evt({"timeout ", name}, n);
  endtask

  task automatic stop_scan();
    enable = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
  endtask

  task automatic drain(input string name);
    check({name, " reads left"}, exp_rd_q.size(), 0);
    check({name, " pixels left"}, exp_pix_q.size(), 0);
    check({name, " latches left"}, exp_lat_q.size(), 0);
    check({name, " oe left"}, exp_oe_q.size(), 0);
    exp_rd_q.delete();
    exp_pix_q.delete();
    exp_lat_q.delete();
    exp_oe_q.delete();
  endtask

  initial begin
    int base, lbase, cbase;
    repeat (2) @(negedge pclk);
    check("reset oe_n", hub_oe_n, 1);
    check("reset hub_addr", hub_addr, 0);
    check("reset rgb", {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}, 0);
    check("reset clk/lat/rd/fd", {hub_clk, hub_lat, mem_rd, frame_done}, 0);
    check("reset raddr", mem_raddr, 0);
    #1 presetn = 1'b1;
    repeat (10) @(negedge pclk);
    #1;
    check("idle without enable reads", rd_cnt, 0);
    check("idle oe_n", hub_oe_n, 1);

    // First row at 64 columns, RAM holds its own address.
    mem_mode = 0; ppr = 10'd64;
    start_q.delete(); lat_cyc_q.delete();
    push_cols(0, 0, 64, 64); push_tail(0, 0);
    base = disp_cnt; lbase = lat_cnt; cbase = clk_cnt;
    enable = 1'b1;
    wait_cnt(0, base + 1, 2000, "row ppr64");
    stop_scan();
    drain("ppr64");
    check("hub_clk rises ppr64", clk_cnt - cbase, 64);
    check("latch pulses ppr64", lat_cnt - lbase, 1);
    if (start_q.size() > 0 && lat_cyc_q.size() > 0) check("shift-to-latch cycles", lat_cyc_q[0] - start_q[0], 257);
    else fail_evt("shift-to-latch cycles", start_q.size());

    // Bit-plane selection and binary-weighted OE.
    mem_mode = 1; ppr = 10'd2;
    start_q.delete();
    for (int p = 0; p < 4; p++) begin
      push_cols(0, p, 2, 2);
      push_tail(0, p);
    end
    base = disp_cnt;
    enable = 1'b1;
    wait_cnt(0, base + 4, 3000, "planes");
    stop_scan();
    drain("planes");
    if (start_q.size() >= 4) begin
      check("plane0 time", start_q[1] - start_q[0], 27);
      check("plane1 time", start_q[2] - start_q[1], 43);
      check("plane2 time", start_q[3] - start_q[2], 75);
    end else fail_evt("plane starts", start_q.size());

    // pixels_per_row boundaries.
    mem_mode = 0; ppr = 10'd0;
    push_cols(0, 0, 64, 64); push_tail(0, 0);
    base = disp_cnt; enable = 1'b1;
    wait_cnt(0, base + 1, 2000, "ppr0");
    stop_scan();
    drain("ppr0");
    ppr = 10'd1000;
    push_cols(0, 0, 512, 512); push_tail(0, 0);
    base = disp_cnt; enable = 1'b1;
    wait_cnt(0, base + 1, 4000, "ppr1000");
    stop_scan();
    drain("ppr1000");

    // Abort mid-shift at column 30, then restart from the top.
    ppr = 10'd64;
    push_cols(0, 0, 31, 30);
    base = rd_cnt; enable = 1'b1;
    wait_cnt(1, base + 62, 1000, "col30");
    enable = 1'b0;
    @(negedge pclk);
    check("abort oe_n", hub_oe_n, 1);
    check("abort hub_clk", hub_clk, 0);
    check("abort mem_rd", mem_rd, 0);
    check("abort hub_lat", hub_lat, 0);
    #1;
    stop_scan();
    drain("abort");
    push_cols(0, 0, 64, 64); push_tail(0, 0);
    base = disp_cnt; enable = 1'b1;
    wait_cnt(0, base + 1, 2000, "restart");
    stop_scan();
    drain("restart");

    // Width change mid-row only applies from the next plane.
    ppr = 10'd64;
    push_cols(0, 0, 64, 64); push_tail(0, 0);
    push_cols(0, 1, 128, 128); push_tail(0, 1);
    base = rd_cnt; enable = 1'b1;
    wait_cnt(1, base + 20, 500, "ppr change point");
    ppr = 10'd128;
    base = disp_cnt;
    wait_cnt(0, base + 1, 2000, "ppr change plane");
    wait_cnt(0, base + 2, 2000, "ppr change plane");
    stop_scan();
    drain("ppr change");

    // Two full frames: frame_done period and hub_addr sequence.
    ppr = 10'd64;
    chk_rd = 0; chk_pix = 0; chk_oe = 0;
    start_q.delete(); fd_q.delete();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 16; r++)
        for (int p = 0; p < 4; p++) exp_lat_q.push_back(4'(r));
    base = fd_cnt; enable = 1'b1;
    wait_cnt(2, base + 2, 45000, "frames");
    stop_scan();
    drain("frames");
    check("frame_done pulses", fd_cnt - base, 2);
    if (start_q.size() > 0 && fd_q.size() >= 2) begin
      check("first frame cycles", fd_q[0] - start_q[0], 20415);
      check("frame period", fd_q[1] - fd_q[0], 20416);
    end else fail_evt("frame timestamps", fd_q.size());
    chk_rd = 1; chk_pix = 1; chk_oe = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
